// File: rtl/es8388_i2c_reg_model_if.sv
// ---------------------------------------------------------------------------
// es8388_i2c_reg_model_if
// Bus/side-port bundle for the ES8388 control-port responder model.
//   scl_i, sda_i  : raw (asynchronous) I2C pin levels seen by the model
//   sda_oe        : 1 = model pulls SDA low (open drain, never drives high)
//   wr_stb        : one-clk pulse per register write, with wr_addr/wr_data
//   busy          : high between START and STOP
//   nack_cnt      : saturating count of NACKs issued by the model
//   peek_addr     : side-port register address
//   peek_data     : registered contents of reg[peek_addr] (0 if out of range)
// slave  : the register model
// master : the environment (bench / init controller side)
// ---------------------------------------------------------------------------
interface es8388_i2c_reg_model_if;
  logic       scl_i;
  logic       sda_i;
  logic       sda_oe;
  logic       wr_stb;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic [7:0] nack_cnt;
  logic [7:0] peek_addr;
  logic [7:0] peek_data;

  modport slave (
    input  scl_i, sda_i, peek_addr,
    output sda_oe, wr_stb, wr_addr, wr_data, busy, nack_cnt, peek_data
  );

  modport master (
    output scl_i, sda_i, peek_addr,
    input  sda_oe, wr_stb, wr_addr, wr_data, busy, nack_cnt, peek_data
  );
endinterface

// File: rtl/es8388_i2c_reg_model.sv
// ---------------------------------------------------------------------------
// es8388_i2c_reg_model
// I2C responder model of the ES8388 codec control port. Holds a shadow
// register file (REG_COUNT x 8 bit), ACKs/NACKs like the codec, supports
// single/burst register writes and current/random-address reads. Everything
// runs on clk; SCL/SDA are oversampled, synchronized and glitch filtered.
// Ports:
//   clk   : system clock (>= 20x SCL)
//   reset : synchronous, active high
//   bus   : es8388_i2c_reg_model_if.slave (pins, write strobe, status, peek)
// ---------------------------------------------------------------------------
module es8388_i2c_reg_model #(
  parameter logic [6:0]  DEV_ADDR  = 7'h10,
  parameter int unsigned REG_COUNT = 53,
  parameter int unsigned FILT_LEN  = 3
) (
  input logic                    clk,
  input logic                    reset,
  es8388_i2c_reg_model_if.slave  bus
);

  localparam int unsigned AW      = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
  localparam int unsigned CW      = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [8:0]  REG_LIM = 9'(REG_COUNT);
  localparam logic [CW-1:0] FILT_LAST = CW'(FILT_LEN - 1);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEV,
    ST_DEV_ACK,
    ST_REG,
    ST_REG_ACK,
    ST_WDAT,
    ST_WDAT_ACK,
    ST_RDAT,
    ST_RDAT_ACK,
    ST_IGNORE
  } state_t;

  // -------------------------------------------------------------------------
  // Input conditioning. Deliberately not reset: the pipeline keeps tracking
  // the real pin levels through a reset, so releasing reset mid-transfer can
  // never manufacture a false START/STOP edge.
  // -------------------------------------------------------------------------
  logic          scl_s1_q, scl_s2_q, scl_filt_q, scl_prev_q;
  logic          sda_s1_q, sda_s2_q, sda_filt_q, sda_prev_q;
  logic [CW-1:0] scl_cnt_q, sda_cnt_q;

  always_ff @(posedge clk) begin
    scl_s1_q   <= bus.scl_i;
    scl_s2_q   <= scl_s1_q;
    sda_s1_q   <= bus.sda_i;
    sda_s2_q   <= sda_s1_q;
    scl_prev_q <= scl_filt_q;
    sda_prev_q <= sda_filt_q;

    // A new level is accepted after FILT_LEN consecutive differing samples.
    if (scl_s2_q == scl_filt_q) begin
      scl_cnt_q <= '0;
    end else if (scl_cnt_q == FILT_LAST) begin
      scl_filt_q <= scl_s2_q;
      scl_cnt_q  <= '0;
    end else begin
      scl_cnt_q <= scl_cnt_q + 1'b1;
    end

    if (sda_s2_q == sda_filt_q) begin
      sda_cnt_q <= '0;
    end else if (sda_cnt_q == FILT_LAST) begin
      sda_filt_q <= sda_s2_q;
      sda_cnt_q  <= '0;
    end else begin
      sda_cnt_q <= sda_cnt_q + 1'b1;
    end
  end

  logic scl_rise, scl_fall, sda_rise, sda_fall, start_c, stop_c;

  always_comb begin
    scl_rise = scl_filt_q & ~scl_prev_q;
    scl_fall = ~scl_filt_q & scl_prev_q;
    sda_rise = sda_filt_q & ~sda_prev_q;
    sda_fall = ~sda_filt_q & sda_prev_q;
    // SCL must have been high on both sides of the SDA edge.
    start_c  = sda_fall & scl_filt_q & scl_prev_q;
    stop_c   = sda_rise & scl_filt_q & scl_prev_q;
  end

  // -------------------------------------------------------------------------
  // Protocol FSM, register file and registered outputs
  // -------------------------------------------------------------------------
  state_t     state_q;
  logic [3:0] bitcnt_q;
  logic [7:0] sh_q;
  logic [7:0] rsh_q;
  logic [7:0] ptr_q;
  logic       sda_oe_q;
  logic       wr_stb_q;
  logic [7:0] wr_addr_q;
  logic [7:0] wr_data_q;
  logic       busy_q;
  logic [7:0] nack_cnt_q;
  logic [7:0] peek_data_q;
  logic [7:0] regs_q [REG_COUNT];

  logic [7:0] rx_byte_d;
  logic       ptr_ok;
  logic       peek_ok;
  logic [7:0] rd_byte;
  logic [7:0] peek_byte;

  always_comb begin
    rx_byte_d = {sh_q[6:0], sda_filt_q};
    ptr_ok    = {1'b0, ptr_q} < REG_LIM;
    peek_ok   = {1'b0, bus.peek_addr} < REG_LIM;
    rd_byte   = '0;
    peek_byte = '0;
    if (ptr_ok)  rd_byte   = regs_q[ptr_q[AW-1:0]];
    if (peek_ok) peek_byte = regs_q[bus.peek_addr[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bitcnt_q    <= '0;
      sh_q        <= '0;
      rsh_q       <= '0;
      ptr_q       <= '0;
      sda_oe_q    <= 1'b0;
      wr_stb_q    <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      busy_q      <= 1'b0;
      nack_cnt_q  <= '0;
      peek_data_q <= '0;
      for (int unsigned i = 0; i < REG_COUNT; i++) begin
        regs_q[AW'(i)] <= '0;
      end
    end else begin
      wr_stb_q    <= 1'b0;
      peek_data_q <= peek_byte;

      if (start_c) begin
        state_q  <= ST_DEV;
        bitcnt_q <= '0;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b1;
      end else if (stop_c) begin
        state_q  <= ST_IDLE;
        bitcnt_q <= '0;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b0;
      end else begin
        unique case (state_q)
          ST_DEV: begin
            if (scl_rise) begin
              sh_q     <= rx_byte_d;
              bitcnt_q <= bitcnt_q + 4'd1;
            end else if (scl_fall && bitcnt_q == 4'd8) begin
              bitcnt_q <= '0;
              if (sh_q[7:1] == DEV_ADDR) begin
                sda_oe_q <= 1'b1;
                state_q  <= ST_DEV_ACK;
              end else begin
                state_q <= ST_IGNORE;
                if (nack_cnt_q != 8'hFF) nack_cnt_q <= nack_cnt_q + 8'd1;
              end
            end
          end

          // sh_q[0] still holds R/W here: nothing shifts during the ACK bit.
          ST_DEV_ACK: begin
            if (scl_fall) begin
              bitcnt_q <= '0;
              if (sh_q[0]) begin
                state_q  <= ST_RDAT;
                sda_oe_q <= ~rd_byte[7];
                rsh_q    <= {rd_byte[6:0], 1'b0};
              end else begin
                state_q  <= ST_REG;
                sda_oe_q <= 1'b0;
              end
            end
          end

          ST_REG: begin
            if (scl_rise) begin
              sh_q     <= rx_byte_d;
              bitcnt_q <= bitcnt_q + 4'd1;
            end else if (scl_fall && bitcnt_q == 4'd8) begin
              ptr_q    <= sh_q;
              sda_oe_q <= 1'b1;
              bitcnt_q <= '0;
              state_q  <= ST_REG_ACK;
            end
          end

          ST_REG_ACK, ST_WDAT_ACK: begin
            if (scl_fall) begin
              sda_oe_q <= 1'b0;
              bitcnt_q <= '0;
              state_q  <= ST_WDAT;
            end
          end

          // The write commits on the 8th rise; ACK/NACK and the pointer
          // increment follow on the next fall, using the unchanged pointer.
          ST_WDAT: begin
            if (scl_rise) begin
              sh_q     <= rx_byte_d;
              bitcnt_q <= bitcnt_q + 4'd1;
              if (bitcnt_q == 4'd7 && ptr_ok) begin
                regs_q[ptr_q[AW-1:0]] <= rx_byte_d;
                wr_stb_q  <= 1'b1;
                wr_addr_q <= ptr_q;
                wr_data_q <= rx_byte_d;
              end
            end else if (scl_fall && bitcnt_q == 4'd8) begin
              bitcnt_q <= '0;
              sda_oe_q <= ptr_ok;
              if (!ptr_ok && nack_cnt_q != 8'hFF) nack_cnt_q <= nack_cnt_q + 8'd1;
              ptr_q    <= ptr_q + 8'd1;
              state_q  <= ST_WDAT_ACK;
            end
          end

          ST_RDAT: begin
            if (scl_rise) begin
              bitcnt_q <= bitcnt_q + 4'd1;
            end else if (scl_fall) begin
              if (bitcnt_q == 4'd8) begin
                sda_oe_q <= 1'b0;
                bitcnt_q <= '0;
                ptr_q    <= ptr_q + 8'd1;
                state_q  <= ST_RDAT_ACK;
              end else begin
                sda_oe_q <= ~rsh_q[7];
                rsh_q    <= {rsh_q[6:0], 1'b0};
              end
            end
          end

          // bitcnt_q == 1 marks "master ACK seen"; the next byte starts on
          // the fall that ends the ACK bit.
          ST_RDAT_ACK: begin
            if (scl_rise) begin
              if (sda_filt_q) state_q <= ST_IGNORE;
              else            bitcnt_q <= 4'd1;
            end else if (scl_fall && bitcnt_q == 4'd1) begin
              bitcnt_q <= '0;
              state_q  <= ST_RDAT;
              sda_oe_q <= ~rd_byte[7];
              rsh_q    <= {rd_byte[6:0], 1'b0};
            end
          end

          ST_IDLE, ST_IGNORE: begin
            sda_oe_q <= 1'b0;
          end

          default: begin
            state_q  <= ST_IDLE;
            sda_oe_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.sda_oe    = sda_oe_q;
  assign bus.wr_stb    = wr_stb_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.busy      = busy_q;
  assign bus.nack_cnt  = nack_cnt_q;
  assign bus.peek_data = peek_data_q;

endmodule

// File: tb/tb_es8388_i2c_reg_model.sv
// ---------------------------------------------------------------------------
// tb_es8388_i2c_reg_model
// Directed bench for es8388_i2c_reg_model: bit-banged I2C master on an
// open-drain SDA, write-strobe logger and peek-port checks.
// ---------------------------------------------------------------------------
module tb_es8388_i2c_reg_model;

  localparam int Q = 100;  // quarter SCL period (clk period is 10)

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic scl_m;
  logic sda_m;

  es8388_i2c_reg_model_if ifc();

  assign ifc.scl_i = scl_m;
  assign ifc.sda_i = sda_m & ~ifc.sda_oe;

  es8388_i2c_reg_model #(
    .DEV_ADDR (7'h10),
    .REG_COUNT(53),
    .FILT_LEN (3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (ifc)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int wr_count = 0;
  logic [7:0] wr_addr_log[$];
  logic [7:0] wr_data_log[$];
  logic oe_seen = 1'b0;

  always @(negedge clk) begin
    if (ifc.wr_stb === 1'b1) begin
      wr_count++;
      wr_addr_log.push_back(ifc.wr_addr);
      wr_data_log.push_back(ifc.wr_data);
    end
    if (ifc.sda_oe === 1'b1) oe_seen = 1'b1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; #Q;
    scl_m = 1'b1; #Q;
    sda_m = 1'b0; #Q;
    scl_m = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; #Q;
    scl_m = 1'b1; #Q;
    sda_m = 1'b1; #Q;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic [7:0] v;
    v = b;
    for (int i = 7; i >= 0; i--) begin
      sda_m = v[i]; #Q;
      scl_m = 1'b1; #(2*Q);
      scl_m = 1'b0; #Q;
    end
    sda_m = 1'b1; #Q;
    scl_m = 1'b1; #Q;
    ack = ifc.sda_i; #Q;
    scl_m = 1'b0; #Q;
  endtask

  task automatic recv_byte(input logic ack_bit, output logic [7:0] b);
    sda_m = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      #Q;
      scl_m = 1'b1; #Q;
      b[i] = ifc.sda_i; #Q;
      scl_m = 1'b0; #Q;
    end
    sda_m = ack_bit; #Q;
    scl_m = 1'b1; #(2*Q);
    scl_m = 1'b0; #Q;
  endtask

  task automatic peek_chk(input string tag, input logic [7:0] a, input logic [7:0] exp);
    ifc.peek_addr = a;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_eq(tag, {24'd0, ifc.peek_data}, {24'd0, exp});
  endtask

  initial begin
    logic       ack;
    logic [7:0] rb;
    int         base;

    reset = 1'b1;
    scl_m = 1'b1;
    sda_m = 1'b1;
    ifc.peek_addr = 8'h00;
    repeat (10) @(posedge clk);
    #1;
    check_eq("rst_sda_oe",   ifc.sda_oe,    0);
    check_eq("rst_wr_stb",   ifc.wr_stb,    0);
    check_eq("rst_wr_addr",  ifc.wr_addr,   0);
    check_eq("rst_wr_data",  ifc.wr_data,   0);
    check_eq("rst_busy",     ifc.busy,      0);
    check_eq("rst_nack_cnt", ifc.nack_cnt,  0);
    check_eq("rst_peek",     ifc.peek_data, 0);
    reset = 1'b0;
    repeat (10) @(posedge clk);

    // Single write: reg 0x00 = 0x80
    i2c_start();
    check_eq("t1_busy_on", ifc.busy, 1);
    send_byte(8'h20, ack); check_eq("t1_ack_dev", ack, 0);
    send_byte(8'h00, ack); check_eq("t1_ack_reg", ack, 0);
    send_byte(8'h80, ack); check_eq("t1_ack_dat", ack, 0);
    i2c_stop();
    check_eq("t1_busy_off", ifc.busy, 0);
    check_eq("t1_wr_count", wr_count, 1);
    check_eq("t1_wr_addr", wr_addr_log[0], 8'h00);
    check_eq("t1_wr_data", wr_data_log[0], 8'h80);
    peek_chk("t1_peek00", 8'h00, 8'h80);

    // Burst write 0x2E..0x31 = 0x1E
    base = wr_count;
    i2c_start();
    send_byte(8'h20, ack); check_eq("t2_ack_dev", ack, 0);
    send_byte(8'h2E, ack); check_eq("t2_ack_reg", ack, 0);
    for (int k = 0; k < 4; k++) begin
      send_byte(8'h1E, ack); check_eq("t2_ack_dat", ack, 0);
    end
    i2c_stop();
    check_eq("t2_wr_count", wr_count - base, 4);
    for (int k = 0; k < 4; k++) begin
      check_eq("t2_wr_addr", wr_addr_log[base+k], 32'h2E + k);
      check_eq("t2_wr_data", wr_data_log[base+k], 8'h1E);
    end
    peek_chk("t2_peek2e", 8'h2E, 8'h1E);
    peek_chk("t2_peek31", 8'h31, 8'h1E);
    peek_chk("t2_peek32", 8'h32, 8'h00);

    // Set reg 0x08 = 0x00, 0x09 = 0x88, then random-address read of two bytes
    i2c_start();
    send_byte(8'h20, ack);
    send_byte(8'h08, ack);
    send_byte(8'h00, ack);
    send_byte(8'h88, ack); check_eq("t3_ack_wr", ack, 0);
    i2c_stop();
    peek_chk("t3_peek09", 8'h09, 8'h88);
    i2c_start();
    send_byte(8'h20, ack); check_eq("t3_ack_dev_w", ack, 0);
    send_byte(8'h08, ack); check_eq("t3_ack_reg", ack, 0);
    i2c_start();
    send_byte(8'h21, ack); check_eq("t3_ack_dev_r", ack, 0);
    recv_byte(1'b0, rb);   check_eq("t3_rd0", rb, 8'h00);
    recv_byte(1'b1, rb);   check_eq("t3_rd1", rb, 8'h88);
    i2c_stop();
    check_eq("t3_oe_after_stop", ifc.sda_oe, 0);
    check_eq("t3_nack_cnt", ifc.nack_cnt, 0);

    // Wrong device address: nothing driven, one NACK counted
    base = wr_count;
    oe_seen = 1'b0;
    i2c_start();
    send_byte(8'h22, ack); check_eq("t4_ack_dev", ack, 1);
    send_byte(8'h00, ack); check_eq("t4_ack_b1", ack, 1);
    send_byte(8'h55, ack); check_eq("t4_ack_b2", ack, 1);
    i2c_stop();
    check_eq("t4_oe_seen", oe_seen, 0);
    check_eq("t4_nack_cnt", ifc.nack_cnt, 1);
    check_eq("t4_wr_count", wr_count - base, 0);
    peek_chk("t4_peek00", 8'h00, 8'h80);

    // Out-of-range register: data byte NACKed, no write
    base = wr_count;
    i2c_start();
    send_byte(8'h20, ack); check_eq("t5_ack_dev", ack, 0);
    send_byte(8'h40, ack); check_eq("t5_ack_reg", ack, 0);
    send_byte(8'hAA, ack); check_eq("t5_ack_dat", ack, 1);
    i2c_stop();
    check_eq("t5_nack_cnt", ifc.nack_cnt, 2);
    check_eq("t5_wr_count", wr_count - base, 0);
    peek_chk("t5_peek40", 8'h40, 8'h00);

    // Reset during bit 4 of a read byte (reg 0x05 = 0x00, so SDA is pulled)
    i2c_start();
    send_byte(8'h20, ack);
    send_byte(8'h05, ack);
    i2c_start();
    send_byte(8'h21, ack); check_eq("t6_ack_dev_r", ack, 0);
    sda_m = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #Q;
      scl_m = 1'b1; #(2*Q);
      scl_m = 1'b0; #Q;
    end
    check_eq("t6_oe_before_rst", ifc.sda_oe, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_eq("t6_oe_after_rst", ifc.sda_oe, 0);
    check_eq("t6_busy_after_rst", ifc.busy, 0);
    check_eq("t6_nack_after_rst", ifc.nack_cnt, 0);
    peek_chk("t6_peek00", 8'h00, 8'h00);
    peek_chk("t6_peek09", 8'h09, 8'h00);
    i2c_stop();
    base = wr_count;
    i2c_start();
    send_byte(8'h20, ack); check_eq("t6_ack_dev", ack, 0);
    send_byte(8'h03, ack); check_eq("t6_ack_reg", ack, 0);
    send_byte(8'h09, ack); check_eq("t6_ack_dat", ack, 0);
    i2c_stop();
    check_eq("t6_wr_count", wr_count - base, 1);
    check_eq("t6_wr_addr", wr_addr_log[base], 8'h03);
    check_eq("t6_wr_data", wr_data_log[base], 8'h09);
    peek_chk("t6_peek03", 8'h03, 8'h09);
    check_eq("t6_nack_cnt", ifc.nack_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/es8388_i2c_reg_model.md
Name: es8388_i2c_reg_model

Overview:
- I2C responder model of the ES8388 codec control port. It is the target side of the codec init sequence: the init controller writes the 43-entry register table to it.
- Holds a shadow register file and ACKs/NACKs like the codec.
- Supports register writes, burst writes and current/random-address reads.
- Used in the loopback bench and the on-chip self-check. A side port lets the bench peek any register without bus traffic.

Parameters:
- DEV_ADDR, 7'h10: 7-bit slave address. On the bus this is 8'h20 for write and 8'h21 for read.
- REG_COUNT, 53: number of implemented registers, 0x00..0x34.
- FILT_LEN, 3: number of consecutive equal synchronized samples needed before an SCL/SDA level change is accepted.

Ports:
- clk, in, 1: system clock, at least 20x the SCL frequency.
- reset, in, 1: synchronous, active-high.
- scl_i, in, 1: SCL pin level, asynchronous.
- sda_i, in, 1: SDA pin level, asynchronous.
- sda_oe, out, 1: 1 pulls SDA low (open-drain). The block never drives SDA high.
- wr_stb, out, 1: one-cycle pulse when a register is written.
- wr_addr, out, 8: register address of the write.
- wr_data, out, 8: data of the write.
- busy, out, 1: high from START until STOP.
- nack_cnt, out, 8: saturating count of NACKs issued.
- peek_addr, in, 8: side-port read address.
- peek_data, out, 8: registered output of reg[peek_addr]; reads 0x00 when the address is out of range.

Behaviour:
- All state is synchronous to clk. The block uses no SCL-clocked logic.
- Input conditioning:
  - Two-FF synchronizer on each of scl_i and sda_i, then the FILT_LEN glitch filter.
  - Edge detection on the filtered signals gives scl_rise, scl_fall, sda_rise and sda_fall.
- Bus conditions:
  - START = sda_fall while filtered SCL is high.
  - STOP = sda_rise while filtered SCL is high.
  - Both are recognized in every state, including mid-byte. They take priority over bit processing in the same cycle.
- Bit timing:
  - SDA is sampled on scl_rise.
  - sda_oe may change only on scl_fall.
  - No clock stretching.
- Reset values:
  - Outputs: sda_oe=0, wr_stb=0, wr_addr=0, wr_data=0, busy=0, nack_cnt=0, peek_data=0.
  - State = IDLE, address pointer = 0.
  - All registers = 0x00.
- Reset asserted mid-transfer: the FSM aborts to IDLE and releases SDA on the next clk edge. It ignores the bus until the next START.
- FSM states: IDLE, DEV, DEV_ACK, REG, REG_ACK, WDAT, WDAT_ACK, RDAT, RDAT_ACK, IGNORE.
  - START from any state goes to DEV and clears the bit counter. A repeated START is handled the same way.
  - DEV: shift 8 bits MSB first.
    - If addr[7:1]==DEV_ADDR: go to DEV_ACK, driving sda_oe=1 for the 9th clock.
    - Otherwise: go to IGNORE without driving (counts as a NACK in nack_cnt).
  - DEV_ACK: release SDA on the scl_fall ending the ACK bit.
    - R/W=0 goes to REG.
    - R/W=1 goes to RDAT; the first data bit is driven on that same scl_fall.
  - REG: shift 8 bits into the pointer. Always ACK, then go to WDAT.
  - WDAT: shift 8 bits.
    - Pointer < REG_COUNT: write reg[ptr]; pulse wr_stb for one clk on the clk after the 8th scl_rise, with wr_addr=ptr and wr_data=byte; ACK.
    - Pointer >= REG_COUNT: no write, no wr_stb; NACK (SDA released), nack_cnt+1.
    - Pointer increments after every data byte, 8-bit wrap 0xFF->0x00. Then WDAT_ACK -> WDAT.
  - RDAT: drive the bits of reg[ptr] MSB first (0x00 if out of range). sda_oe = ~bit. Release SDA after bit 0. The pointer increments at the end of the byte.
  - RDAT_ACK: sample the master ACK on scl_rise.
    - ACK (0): go to RDAT.
    - NACK (1): go to IGNORE.
  - IGNORE: SDA released. Wait for START or STOP.
  - STOP from any state goes to IDLE with sda_oe=0 on the next clk. The pointer is retained for current-address reads.
- busy: set the cycle after START, cleared the cycle after STOP.
- peek_data latency: 1 clk. A register written in cycle N is visible on peek_data at N+2.
- nack_cnt saturates at 0xFF. It does not count master NACKs on reads.

Test Plan:
- Write 0x20, 0x00, 0x80, STOP → ACK on all three bytes; wr_stb once with wr_addr=0x00, wr_data=0x80; peek 0x00 = 0x80.
- Burst 0x20, 0x2E, 0x1E, 0x1E, 0x1E, 0x1E → four wr_stb pulses with addresses 0x2E..0x31, data 0x1E; registers 0x2E–0x31 = 0x1E.
- After writing reg 0x08=0x00 and reg 0x09=0x88: send 0x20, 0x08, repeated START, 0x21, read two bytes (ACK then NACK), STOP → SDA returns 0x00 then 0x88; sda_oe=0 after STOP.
- Address 0x22 (wrong device), 0x00, 0x55 → no ACK on any bit; nack_cnt=1; no wr_stb; reg 0x00 unchanged.
- Write 0x20, 0x40, 0xAA → ACK on the register byte, NACK on the data byte; nack_cnt+1; peek 0x40 = 0x00.
- Assert reset for 1 clk during bit 4 of a data byte → sda_oe=0 next clk; registers return to 0x00; a following write transaction 0x20, 0x03, 0x09 completes normally.
